// File: rtl/n_divider_if.sv
// ---------------------------------------------------------------------------
// n_divider_if
// Purpose : groups the ratio/feedback-clock pair of the DPLL feedback divider.
// Signals :
//   N    [7:0]  division ratio driven by the loop controller (0 = disabled)
//   out         divided feedback clock returned to the phase detector
// Modports:
//   master - loop controller side: drives N, observes out
//   slave  - divider side: reads N, drives out
// ---------------------------------------------------------------------------
interface n_divider_if;
    logic [7:0] N;
    logic       out;

    modport master (output N, input  out);
    modport slave  (input  N, output out);
endinterface

// File: rtl/n_divider.sv
// ---------------------------------------------------------------------------
// n_divider
// Purpose : programmable integer clock divider for the DPLL feedback path.
//           Produces a registered square wave with a period of N clocks,
//           high for ceil(N/2) clocks at the start of each period.
// Ports   :
//   clk    system clock, all state changes on its rising edge
//   reset  synchronous, active-high; clears all state
//   div    n_divider_if.slave (N in, out out)
// Build option:
//   NDIV_SYNC_LOAD_EN defined   - N is sampled only while idle and at the
//                                 terminal count, so a period is never
//                                 shortened or stretched by an N change.
//   NDIV_SYNC_LOAD_EN undefined - the active ratio tracks N every edge;
//                                 terminal count and high length use the
//                                 live N, and N = 0 goes idle immediately.
// ---------------------------------------------------------------------------
module n_divider (
    input  logic         clk,
    input  logic         reset,
    n_divider_if.slave   div
);

    logic [7:0] cnt_q, cnt_d;   // position within the current period
    logic [7:0] np_q,  np_d;    // active ratio, 0 = idle
    logic       out_q, out_d;   // registered divided clock

    logic [8:0] cnt_inc;        // cnt + 1, widened for the high-length compare
    logic [8:0] hi;             // ceil(ratio/2), 9 bits so 255 gives 128
    logic       term;           // terminal count reached this cycle

    assign cnt_inc = {1'b0, cnt_q} + 9'd1;

`ifdef NDIV_SYNC_LOAD_EN
    logic [7:0] np_m1;

    assign np_m1 = np_q - 8'd1;
    assign hi    = ({1'b0, np_q} + 9'd1) >> 1;
    assign term  = (cnt_q == np_m1);

    always_comb begin
        cnt_d = cnt_q;
        np_d  = np_q;
        out_d = out_q;
        if ((np_q == 8'd0) || term) begin
            // Period boundary (or idle): the only place N is sampled.
            cnt_d = 8'd0;
            np_d  = div.N;
            out_d = (div.N != 8'd0);
        end else begin
            cnt_d = cnt_q + 8'd1;
            out_d = (cnt_inc < hi);
        end
    end
`else
    logic [8:0] n_m1;

    // n_m1 is only meaningful when N != 0; the N == 0 case is handled first.
    assign n_m1 = {1'b0, div.N} - 9'd1;
    assign hi   = ({1'b0, div.N} + 9'd1) >> 1;
    assign term = ({1'b0, cnt_q} >= n_m1);

    always_comb begin
        cnt_d = cnt_q;
        np_d  = div.N;          // active ratio follows N on every edge
        out_d = out_q;
        if ((np_q == 8'd0) || (div.N == 8'd0) || term) begin
            // Idle, forced idle, or a boundary (possibly cut short by a
            // shrinking N): restart the period with the live ratio.
            cnt_d = 8'd0;
            out_d = (div.N != 8'd0);
        end else begin
            cnt_d = cnt_q + 8'd1;
            out_d = (cnt_inc < hi);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 8'd0;
            np_q  <= 8'd0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            np_q  <= np_d;
            out_q <= out_d;
        end
    end

    assign div.out = out_q;

endmodule

// File: tb/tb_n_divider.sv
// ---------------------------------------------------------------------------
// tb_n_divider
// Self-checking bench for n_divider. The reference model is a queue of the
// expected output waveform: whenever a new period starts, the whole period
// (ceil(N/2) ones followed by floor(N/2) zeros) is appended, and each clock
// edge consumes one entry. An idle edge (N = 0) contributes a single 0.
// ---------------------------------------------------------------------------
module tb_n_divider;

    logic clk;
    logic reset;

    n_divider_if bus ();

    n_divider dut (
        .clk   (clk),
        .reset (reset),
        .div   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   exp_q[$];       // expected out values for upcoming edges
    bit   idle_now = 1'b1; // divider is idle: next edge samples N in any build

    // One clock edge with the given reset/N, then compare out to the model.
    task automatic step(input logic rst_v, input logic [7:0] n_v, input string tag);
        bit expv;
        int hi_len;
        reset  = rst_v;
        bus.N  = n_v;
        @(posedge clk);
        if (rst_v) begin
            exp_q.delete();
            expv     = 1'b0;
            idle_now = 1'b1;
        end else begin
            idle_now = 1'b0;
            if (exp_q.size() == 0) begin
                if (n_v == 8'd0) begin
                    exp_q.push_back(1'b0);
                    idle_now = 1'b1;
                end else begin
                    hi_len = (int'(n_v) + 1) / 2;
                    for (int i = 0; i < int'(n_v); i++)
                        exp_q.push_back(i < hi_len);
                end
            end
            expv = exp_q.pop_front();
        end
        #1;
        n_checks++;
        assert (bus.out === expv)
        else begin
            n_fail++;
            $error("FAIL %s: out=%b expected %b (N=%0d reset=%b)", tag, bus.out, expv, n_v, rst_v);
        end
    endtask

    initial begin
        logic       r;
        logic [7:0] n_cur;
        reset = 1'b1;
        bus.N = 8'd0;

        // Reset held with N = 4, then release: 1,1,0,0 repeating.
        for (int i = 0; i < 50; i++) step(1'b1, 8'd4, "reset_hold");
        for (int i = 0; i < 12; i++) step(1'b0, 8'd4, "n4");

        // N = 0 keeps the divider idle; then N = 3 starts it on the next edge.
        step(1'b1, 8'd0, "reset");
        for (int i = 0; i < 8; i++)  step(1'b0, 8'd0, "n0_idle");
        for (int i = 0; i < 9; i++)  step(1'b0, 8'd3, "n3");

        // Odd and extreme ratios.
        step(1'b1, 8'd5, "reset");
        for (int i = 0; i < 10; i++) step(1'b0, 8'd5, "n5");
        step(1'b1, 8'd1, "reset");
        for (int i = 0; i < 6; i++)  step(1'b0, 8'd1, "n1");
        step(1'b1, 8'd255, "reset");
        for (int i = 0; i < 512; i++) step(1'b0, 8'd255, "n255");

        // Mid-period change from 8 to 2 at cnt = 3.
        step(1'b1, 8'd8, "reset");
        for (int i = 0; i < 4; i++)  step(1'b0, 8'd8, "n8");
`ifndef NDIV_SYNC_LOAD_EN
        exp_q.delete();   // live-N build wraps on the next edge
`endif
        for (int i = 0; i < 10; i++) step(1'b0, 8'd2, "mid_change");

        // Reset in the middle of an N = 6 period, then a clean restart.
        step(1'b1, 8'd6, "reset");
        for (int i = 0; i < 3; i++)  step(1'b0, 8'd6, "n6");
        step(1'b1, 8'd6, "reset_mid");
        for (int i = 0; i < 12; i++) step(1'b0, 8'd6, "n6_restart");

        // N dropped to 0 one edge into an N = 4 period.
        step(1'b1, 8'd4, "reset");
        step(1'b0, 8'd4, "n4_run");
`ifndef NDIV_SYNC_LOAD_EN
        exp_q.delete();   // live-N build goes idle on the next edge
`endif
        for (int i = 0; i < 8; i++)  step(1'b0, 8'd0, "n_to_0");

        // Randomised run. N is changed whenever the model can predict the
        // result in the active build: anywhere when N is sampled only at
        // boundaries, otherwise only while idle or under reset.
        step(1'b1, 8'd0, "reset");
        n_cur = 8'd0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 79) == 0);
`ifdef NDIV_SYNC_LOAD_EN
            if ($urandom_range(0, 7) == 0)
`else
            if (r || idle_now)
`endif
            begin
                case ($urandom_range(0, 3))
                    0:       n_cur = 8'd0;
                    1:       n_cur = 8'($urandom_range(1, 40));
                    default: n_cur = 8'($urandom_range(1, 9));
                endcase
            end
            step(r, n_cur, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
